// File: rtl/fpga2cpu_pkt_writer.sv
// fpga2cpu_pkt_writer: packs an incoming packet flit stream into one PDU per packet
// inside the FPGA-side ring buffer. Body flits land at offsets 1..N, the header flit
// is written last at offset 0, then the PDU is committed with a one-cycle update_valid.
// Oversize or aborted packets are never committed, so the buffer reuses their space.

package fpga2cpu_pkt_writer_pkg;
  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } flit_lite_t;
endpackage

// state  | meaning
// IDLE   | waiting for sop; non-sop flits are swallowed; stalls while almost_full
// BODY   | writing body flits of the current packet at offset flit_cnt+1
// DROP   | packet too long; discard flits until eop
// HDR    | one cycle: write header flit at offset 0
// COMMIT | one cycle: pulse update_valid with the PDU size
module fpga2cpu_pkt_writer
  import fpga2cpu_pkt_writer_pkg::*;
#(
  parameter int PDU_AWIDTH    = 10,
  parameter int MAX_PKT_FLITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [511:0]          in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [5:0]            in_empty,
  output logic                  in_ready,
  output flit_lite_t            wr_data,
  output logic [PDU_AWIDTH-1:0] wr_addr,
  output logic                  wr_en,
  input  logic [PDU_AWIDTH-1:0] wr_base_addr,
  input  logic                  almost_full,
  output logic                  update_valid,
  output logic [PDU_AWIDTH-1:0] update_size,
  output logic [31:0]           pkt_cnt,
  output logic [31:0]           drop_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BODY   = 3'd1;
  localparam logic [2:0] S_DROP   = 3'd2;
  localparam logic [2:0] S_HDR    = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  localparam logic [5:0] MAX_CNT = 6'(MAX_PKT_FLITS);

  logic [2:0]            state;
  logic [5:0]            flit_cnt;
  logic [5:0]            last_empty;
  logic [31:0]           seq;
  logic                  accept;
  flit_lite_t            in_flit;
  flit_lite_t            hdr_flit;
  logic [15:0]           hdr_bytes;
  logic [PDU_AWIDTH-1:0] next_off;

  // The base address is owned by the ring buffer; it is informational here.
  logic base_addr_unused;
  assign base_addr_unused = ^wr_base_addr;

  // almost_full only gates the start of a packet: the free-space guarantee covers a
  // maximum-length packet, so once in BODY the stream never stalls.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = ((state == S_IDLE) && !almost_full) ||
                 (state == S_BODY) || (state == S_DROP);
    end
  end

  assign accept   = in_valid && in_ready;
  assign in_flit  = {in_data, in_sop, in_eop, in_empty};
  assign next_off = PDU_AWIDTH'(flit_cnt) + PDU_AWIDTH'(1);

  // Header flit contents: byte count, flit count and sequence number; rest zero.
  always_comb begin
    hdr_bytes      = {4'd0, flit_cnt, 6'd0} - {10'd0, last_empty};
    hdr_flit.data  = {448'd0, seq, 10'd0, flit_cnt, hdr_bytes};
    hdr_flit.sop   = 1'b1;
    hdr_flit.eop   = 1'b1;
    hdr_flit.empty = 6'd0;
  end

  // Packet sequencing; all ring-buffer outputs are registered one cycle after the decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      flit_cnt     <= '0;
      last_empty   <= '0;
      seq          <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      update_valid <= 1'b0;
      update_size  <= '0;
      pkt_cnt      <= '0;
      drop_cnt     <= '0;
    end else begin
      wr_en        <= 1'b0;
      update_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && in_sop) begin
            wr_en      <= 1'b1;
            wr_addr    <= PDU_AWIDTH'(1);
            wr_data    <= in_flit;
            flit_cnt   <= 6'd1;
            last_empty <= in_empty;
            state      <= in_eop ? S_HDR : S_BODY;
          end
        end
        S_BODY: begin
          if (accept) begin
            if (in_sop) begin
              // abort: the open packet is lost, this flit opens a fresh one
              drop_cnt   <= drop_cnt + 32'd1;
              wr_en      <= 1'b1;
              wr_addr    <= PDU_AWIDTH'(1);
              wr_data    <= in_flit;
              flit_cnt   <= 6'd1;
              last_empty <= in_empty;
              state      <= in_eop ? S_HDR : S_BODY;
            end else if (flit_cnt == MAX_CNT) begin
              drop_cnt <= drop_cnt + 32'd1;
              state    <= in_eop ? S_IDLE : S_DROP;
            end else begin
              wr_en    <= 1'b1;
              wr_addr  <= next_off;
              wr_data  <= in_flit;
              flit_cnt <= flit_cnt + 6'd1;
              if (in_eop) begin
                last_empty <= in_empty;
                state      <= S_HDR;
              end
            end
          end
        end
        S_DROP: begin
          if (accept && in_eop) begin
            state <= S_IDLE;
          end
        end
        S_HDR: begin
          wr_en   <= 1'b1;
          wr_addr <= '0;
          wr_data <= hdr_flit;
          state   <= S_COMMIT;
        end
        S_COMMIT: begin
          update_valid <= 1'b1;
          update_size  <= next_off;
          pkt_cnt      <= pkt_cnt + 32'd1;
          seq          <= seq + 32'd1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
